// File: rtl/ctrl_mem.sv
// ctrl_mem: memory-access control stage running the LDR/STR data-bus handshake
// Ports: clk/rst (sync, active-high); i_ir_mem/i_valid/i_addr/i_wdata from execute;
//        o_mem_req/o_mem_we/o_mem_addr/o_mem_wdata, i_mem_ack/i_mem_rdata to the data bus;
//        o_ir_wb/o_load_data to writeback; o_stall holds upstream; o_bus_err error pulse.
module ctrl_mem #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       i_ir_mem,
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic              i_mem_ack,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [15:0]       o_ir_wb,
    output logic [DATA_W-1:0] o_load_data,
    output logic              o_stall,
    output logic              o_bus_err
);
    typedef enum logic {IDLE, ACCESS} state_t;
    localparam int CW = $clog2(TIMEOUT);
    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              req_q, req_d, we_q, we_d, err_q, err_d, stall;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, load_q, load_d;
    logic [15:0]       ir_q, ir_d, ir_wb_q, ir_wb_d;
    logic              is_ldr, is_str, is_mem, aligned, timeout;
    assign is_ldr  = i_ir_mem[15:11] == 5'b01101;
    assign is_str  = i_ir_mem[15:11] == 5'b01100;
    assign is_mem  = i_valid & (is_ldr | is_str);
    assign aligned = i_addr[1:0] == 2'b00;
    assign timeout = cnt_q == CW'(TIMEOUT - 1);
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ir_d    = ir_q;
        load_d  = load_q;
        ir_wb_d = 16'h0000;
        err_d   = 1'b0;
        stall   = 1'b0;
        if (state_q == IDLE) begin
            if (!is_mem) begin
                ir_wb_d = i_valid ? i_ir_mem : 16'h0000;
            end else if (!aligned) begin
                err_d = 1'b1;
            end else begin
                stall   = 1'b1;
                state_d = ACCESS;
                req_d   = 1'b1;
                we_d    = is_str;
                addr_d  = i_addr;
                wdata_d = i_wdata;
                ir_d    = i_ir_mem;
                cnt_d   = '0;
            end
        end else if (i_mem_ack) begin
            // ack beats a simultaneous timeout
            state_d = IDLE;
            req_d   = 1'b0;
            ir_wb_d = ir_q;
            load_d  = we_q ? load_q : i_mem_rdata;
        end else if (timeout) begin
            state_d = IDLE;
            req_d   = 1'b0;
            err_d   = 1'b1;
        end else begin
            stall = 1'b1;
            cnt_d = cnt_q + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ir_q    <= 16'h0000;
            ir_wb_q <= 16'h0000;
            load_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ir_q    <= ir_d;
            ir_wb_q <= ir_wb_d;
            load_q  <= load_d;
            err_q   <= err_d;
        end
    end
    assign o_stall     = stall & ~rst;
    assign o_mem_req   = req_q;
    assign o_mem_we    = we_q;
    assign o_mem_addr  = addr_q;
    assign o_mem_wdata = wdata_q;
    assign o_ir_wb     = ir_wb_q;
    assign o_load_data = load_q;
    assign o_bus_err   = err_q;
endmodule
